// File: rtl/i2s_receiver.sv
// ---------------------------------------------------------------------------
// i2s_receiver
//
// Purpose:
//   Receives a standard I2S stereo stream (one-bit-delayed word select,
//   MSB first) whose bit clock is asynchronous to the system clock. It
//   oversamples sclk/lrclk/sd with clk, tracks frame alignment, and presents
//   each complete left/right pair as two signed words with a one-cycle valid
//   strobe. Malformed words (too short or too long) raise a one-cycle
//   frame_err and force re-acquisition.
//
// Ports:
//   clk        in   system clock, everything on its rising edge
//   rst        in   synchronous active-high reset
//   enable     in   receive enable; low forces re-acquisition, outputs hold
//   sclk       in   serial bit clock (async to clk, clk >= 4x sclk)
//   lrclk      in   word select, 0 = left, 1 = right (async)
//   sd         in   serial data, MSB first (async)
//   left_data  out  last complete left sample (signed, WIDTH bits)
//   right_data out  last complete right sample (signed, WIDTH bits)
//   valid      out  one-clk pulse when left_data/right_data update
//   frame_err  out  one-clk pulse on a malformed word
//   synced     out  high while frame-aligned
// ---------------------------------------------------------------------------
module i2s_receiver #(
  parameter int WIDTH = 24
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic                    sclk,
  input  logic                    lrclk,
  input  logic                    sd,
  output logic signed [WIDTH-1:0] left_data,
  output logic signed [WIDTH-1:0] right_data,
  output logic                    valid,
  output logic                    frame_err,
  output logic                    synced
);

  // The counter has to reach WIDTH+1 so that a long word is distinguishable
  // from a correct one at the boundary.
  localparam int CW = $clog2(WIDTH + 2);
  localparam logic [CW-1:0] CNT_FULL = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_MAX  = CW'(WIDTH + 1);

  typedef enum logic [1:0] {
    SYNC  = 2'd0,
    LEFT  = 2'd1,
    RIGHT = 2'd2
  } state_t;

  // Synchronizers and edge detect
  logic sclk_meta, sclk_sync, sclk_prev;
  logic lrclk_meta, lrclk_sync;
  logic sd_meta, sd_sync;

  // Registered bit event: one clk wide, carries the sampled data and word select
  logic bit_evt, bit_sd, bit_ws;
  logic ws_d;

  // Framing state
  state_t            state, state_next;
  logic [CW-1:0]     count, count_next, count_inc;
  logic [WIDTH-1:0]  shift_reg, shift_next, shift_in;
  logic [WIDTH-1:0]  left_hold, left_hold_next;
  logic [WIDTH-1:0]  right_hold, right_hold_next;
  logic              pair_done, pair_done_next;
  logic              word_err, word_err_next;

  assign synced = (state != SYNC);

  // Input capture: two flops per async input, one more flop on sclk for the
  // rising-edge detect. The detected edge is registered together with sd and
  // lrclk so the FSM sees a clean single-cycle event with matching data.
  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_meta  <= 1'b0;
      sclk_sync  <= 1'b0;
      sclk_prev  <= 1'b0;
      lrclk_meta <= 1'b0;
      lrclk_sync <= 1'b0;
      sd_meta    <= 1'b0;
      sd_sync    <= 1'b0;
      bit_evt    <= 1'b0;
      bit_sd     <= 1'b0;
      bit_ws     <= 1'b0;
      ws_d       <= 1'b0;
    end else begin
      sclk_meta  <= sclk;
      sclk_sync  <= sclk_meta;
      sclk_prev  <= sclk_sync;
      lrclk_meta <= lrclk;
      lrclk_sync <= lrclk_meta;
      sd_meta    <= sd;
      sd_sync    <= sd_meta;
      bit_evt    <= sclk_sync & ~sclk_prev;
      bit_sd     <= sd_sync;
      bit_ws     <= lrclk_sync;
      if (bit_evt) begin
        ws_d <= bit_ws;
      end
    end
  end

  // FSM state and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= SYNC;
      count      <= '0;
      shift_reg  <= '0;
      left_hold  <= '0;
      right_hold <= '0;
      pair_done  <= 1'b0;
      word_err   <= 1'b0;
    end else begin
      state      <= state_next;
      count      <= count_next;
      shift_reg  <= shift_next;
      left_hold  <= left_hold_next;
      right_hold <= right_hold_next;
      pair_done  <= pair_done_next;
      word_err   <= word_err_next;
    end
  end

  assign count_inc = (count == CNT_MAX) ? count : count + CW'(1);
  assign shift_in  = {shift_reg[WIDTH-2:0], bit_sd};

  // Next-state logic. A boundary bit is the one where lrclk has already
  // flipped to the other channel; it is the LSB of the word being received
  // and is counted, so a correct word reaches exactly WIDTH at the boundary.
  always_comb begin
    state_next      = state;
    count_next      = count;
    shift_next      = shift_reg;
    left_hold_next  = left_hold;
    right_hold_next = right_hold;
    pair_done_next  = 1'b0;
    word_err_next   = 1'b0;

    if (!enable) begin
      state_next = SYNC;
      count_next = '0;
    end else if (bit_evt) begin
      case (state)
        SYNC: begin
          // The right-LSB bit (lrclk 1 -> 0) marks the start of a left word.
          if (ws_d && !bit_ws) begin
            state_next = LEFT;
            count_next = '0;
          end
        end
        LEFT: begin
          shift_next = shift_in;
          count_next = count_inc;
          if (bit_ws) begin
            count_next = '0;
            if (count_inc == CNT_FULL) begin
              left_hold_next = shift_in;
              state_next     = RIGHT;
            end else begin
              word_err_next = 1'b1;
              state_next    = SYNC;
            end
          end
        end
        RIGHT: begin
          shift_next = shift_in;
          count_next = count_inc;
          if (!bit_ws) begin
            count_next = '0;
            if (count_inc == CNT_FULL) begin
              right_hold_next = shift_in;
              pair_done_next  = 1'b1;
              state_next      = LEFT;
            end else begin
              word_err_next = 1'b1;
              state_next    = SYNC;
            end
          end
        end
        default: begin
          state_next = SYNC;
          count_next = '0;
        end
      endcase
    end
  end

  // Output stage: both channels update together with valid. Gating with
  // enable keeps a pulse already in flight from escaping after disable.
  always_ff @(posedge clk) begin
    if (rst) begin
      left_data  <= '0;
      right_data <= '0;
      valid      <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      valid     <= pair_done & enable;
      frame_err <= word_err & enable;
      if (pair_done && enable) begin
        left_data  <= left_hold;
        right_data <= right_hold;
      end
    end
  end

endmodule

// File: tb/tb_i2s_receiver.sv
// ---------------------------------------------------------------------------
// tb_i2s_receiver
//
// Purpose:
//   Self-checking bench for i2s_receiver (WIDTH = 24, sclk = clk/40). An I2S
//   transmitter model drives sclk/lrclk/sd; expected sample pairs are queued
//   when a frame is sent and popped by a monitor on every valid pulse.
// ---------------------------------------------------------------------------
module tb_i2s_receiver;

  localparam int WIDTH = 24;
  localparam int HALF  = 20;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    enable;
  logic                    sclk;
  logic                    lrclk;
  logic                    sd;
  logic signed [WIDTH-1:0] left_data;
  logic signed [WIDTH-1:0] right_data;
  logic                    valid;
  logic                    frame_err;
  logic                    synced;

  int total_cnt  = 0;
  int pass_cnt   = 0;
  int err_pulses = 0;

  logic [WIDTH-1:0] exp_left_q[$];
  logic [WIDTH-1:0] exp_right_q[$];
  logic [WIDTH-1:0] last_left  = '0;
  logic [WIDTH-1:0] last_right = '0;
  logic [WIDTH-1:0] mon_l, mon_r;
  logic             prev_valid = 1'b0;
  logic             prev_err   = 1'b0;

  i2s_receiver #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .sclk       (sclk),
    .lrclk      (lrclk),
    .sd         (sd),
    .left_data  (left_data),
    .right_data (right_data),
    .valid      (valid),
    .frame_err  (frame_err),
    .synced     (synced)
  );

  always #5 clk = ~clk;

  // Monitor: scoreboard compare on valid, pulse shape checks on any pulse.
  always @(negedge clk) begin
    if (frame_err) err_pulses++;
    if (valid || frame_err) begin
      total_cnt++;
      if (valid && frame_err)
        $display("[TB] FAIL pulse_overlap valid=%b frame_err=%b required not both high", valid, frame_err);
      else if ((valid && prev_valid) || (frame_err && prev_err))
        $display("[TB] FAIL pulse_width valid=%b/%b err=%b/%b required single-cycle pulses", prev_valid, valid, prev_err, frame_err);
      else
        pass_cnt++;
    end
    if (valid) begin
      if (exp_left_q.size() == 0) begin
        total_cnt++;
        $display("[TB] FAIL unexpected_valid got valid=1 left=%h right=%h required no valid", left_data, right_data);
      end else begin
        mon_l = exp_left_q.pop_front();
        mon_r = exp_right_q.pop_front();
        total_cnt++;
        if (left_data !== mon_l)
          $display("[TB] FAIL sb_left got %h required %h", left_data, mon_l);
        else
          pass_cnt++;
        total_cnt++;
        if (right_data !== mon_r)
          $display("[TB] FAIL sb_right got %h required %h", right_data, mon_r);
        else
          pass_cnt++;
      end
    end
    prev_valid = valid;
    prev_err   = frame_err;
  end

  // One sclk period: data and word select change while sclk is low and are
  // sampled by the receiver on the rising edge.
  task automatic send_bit(input logic ws, input logic b);
    @(negedge clk);
    sclk  = 1'b0;
    lrclk = ws;
    sd    = b;
    repeat (HALF - 1) @(negedge clk);
    sclk = 1'b1;
    repeat (HALF) @(negedge clk);
  endtask

  // A word of n bits on channel ws; the LSB goes out with lrclk already
  // flipped, which is the one-bit I2S delay.
  task automatic send_word(input logic ws, input logic [31:0] data, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      send_bit((i == 0) ? ~ws : ws, data[i]);
    end
  endtask

  task automatic send_frame(input logic [31:0] l, input logic [31:0] r);
    send_word(1'b0, l, WIDTH);
    send_word(1'b1, r, WIDTH);
  endtask

  task automatic push_exp(input logic [WIDTH-1:0] l, input logic [WIDTH-1:0] r);
    exp_left_q.push_back(l);
    exp_right_q.push_back(r);
    last_left  = l;
    last_right = r;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    last_left  = '0;
    last_right = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (5) @(negedge clk);
    total_cnt++;
    if (left_data !== '0) $display("[TB] FAIL reset_left got %h required 0", left_data);
    else pass_cnt++;
    total_cnt++;
    if (right_data !== '0) $display("[TB] FAIL reset_right got %h required 0", right_data);
    else pass_cnt++;
    total_cnt++;
    if (valid !== 1'b0) $display("[TB] FAIL reset_valid got %b required 0", valid);
    else pass_cnt++;
    total_cnt++;
    if (frame_err !== 1'b0) $display("[TB] FAIL reset_frame_err got %b required 0", frame_err);
    else pass_cnt++;
    rst = 1'b0;
    @(negedge clk);
    total_cnt++;
    if (synced !== 1'b0) $display("[TB] FAIL reset_synced got %b required 0", synced);
    else pass_cnt++;
  endtask

  task automatic test_basic();
    int e0;
    e0 = err_pulses;
    send_word(1'b1, 32'h0, WIDTH);
    total_cnt++;
    if (synced !== 1'b1) $display("[TB] FAIL basic_synced got %b required 1", synced);
    else pass_cnt++;
    for (int f = 0; f < 3; f++) begin
      push_exp(24'h123456, 24'hFEDCBA);
      send_frame(32'h123456, 32'hFEDCBA);
    end
    total_cnt++;
    if (exp_left_q.size() != 0) $display("[TB] FAIL basic_pending got %0d required 0", exp_left_q.size());
    else pass_cnt++;
    total_cnt++;
    if (err_pulses != e0) $display("[TB] FAIL basic_frame_err got %0d required %0d", err_pulses, e0);
    else pass_cnt++;
    total_cnt++;
    if (right_data[WIDTH-1] !== 1'b1) $display("[TB] FAIL basic_right_sign got %b required 1", right_data[WIDTH-1]);
    else pass_cnt++;
  endtask

  task automatic test_mid_right();
    logic [31:0] partial;
    partial = 32'h0002AB;
    pulse_reset();
    for (int i = 9; i >= 1; i--) send_bit(1'b1, partial[i]);
    total_cnt++;
    if (synced !== 1'b0) $display("[TB] FAIL mid_unsynced got %b required 0", synced);
    else pass_cnt++;
    send_bit(1'b0, partial[0]);
    total_cnt++;
    if (synced !== 1'b1) $display("[TB] FAIL mid_synced got %b required 1", synced);
    else pass_cnt++;
    total_cnt++;
    if (left_data !== '0) $display("[TB] FAIL mid_dropped got %h required 0", left_data);
    else pass_cnt++;
    push_exp(24'h0A0B0C, 24'h7FFFFF);
    send_frame(32'h0A0B0C, 32'h7FFFFF);
    total_cnt++;
    if (exp_left_q.size() != 0) $display("[TB] FAIL mid_pending got %0d required 0", exp_left_q.size());
    else pass_cnt++;
  endtask

  task automatic test_short_left();
    int e0;
    e0 = err_pulses;
    send_word(1'b0, 32'h0055AA, WIDTH - 1);
    total_cnt++;
    if (err_pulses != e0 + 1) $display("[TB] FAIL short_err got %0d required %0d", err_pulses, e0 + 1);
    else pass_cnt++;
    total_cnt++;
    if (synced !== 1'b0) $display("[TB] FAIL short_synced got %b required 0", synced);
    else pass_cnt++;
    total_cnt++;
    if (left_data !== last_left || right_data !== last_right)
      $display("[TB] FAIL short_hold got %h/%h required %h/%h", left_data, right_data, last_left, last_right);
    else pass_cnt++;
    send_word(1'b1, 32'h00ABCD, WIDTH);
    total_cnt++;
    if (synced !== 1'b1) $display("[TB] FAIL short_resync got %b required 1", synced);
    else pass_cnt++;
    push_exp(24'h3C3C3C, 24'h800001);
    send_frame(32'h3C3C3C, 32'h800001);
    total_cnt++;
    if (exp_left_q.size() != 0) $display("[TB] FAIL short_pending got %0d required 0", exp_left_q.size());
    else pass_cnt++;
  endtask

  task automatic test_long_right();
    int e0;
    e0 = err_pulses;
    send_word(1'b0, 32'h111111, WIDTH);
    send_word(1'b1, 32'h1222222, WIDTH + 1);
    total_cnt++;
    if (err_pulses != e0 + 1) $display("[TB] FAIL long_err got %0d required %0d", err_pulses, e0 + 1);
    else pass_cnt++;
    total_cnt++;
    if (left_data !== last_left || right_data !== last_right)
      $display("[TB] FAIL long_hold got %h/%h required %h/%h", left_data, right_data, last_left, last_right);
    else pass_cnt++;
    total_cnt++;
    if (synced !== 1'b0) $display("[TB] FAIL long_synced got %b required 0", synced);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    int e0;
    logic [31:0] lw;
    lw = 32'h0F0F0F;
    send_word(1'b1, 32'h0, WIDTH);
    push_exp(24'h654321, 24'h000F00);
    send_frame(32'h654321, 32'h000F00);
    e0 = err_pulses;
    for (int i = WIDTH - 1; i >= WIDTH - 10; i--) send_bit(1'b0, lw[i]);
    pulse_reset();
    total_cnt++;
    if (left_data !== '0 || right_data !== '0)
      $display("[TB] FAIL rstmid_data got %h/%h required 0/0", left_data, right_data);
    else pass_cnt++;
    total_cnt++;
    if (synced !== 1'b0 || valid !== 1'b0 || frame_err !== 1'b0)
      $display("[TB] FAIL rstmid_flags got synced=%b valid=%b err=%b required 0/0/0", synced, valid, frame_err);
    else pass_cnt++;
    for (int i = WIDTH - 11; i >= 1; i--) send_bit(1'b0, lw[i]);
    send_bit(1'b1, lw[0]);
    send_word(1'b1, 32'h333333, WIDTH);
    push_exp(24'hA5A5A5, 24'h5A5A5A);
    send_frame(32'hA5A5A5, 32'h5A5A5A);
    total_cnt++;
    if (exp_left_q.size() != 0) $display("[TB] FAIL rstmid_pending got %0d required 0", exp_left_q.size());
    else pass_cnt++;
    total_cnt++;
    if (err_pulses != e0) $display("[TB] FAIL rstmid_err got %0d required %0d", err_pulses, e0);
    else pass_cnt++;
  endtask

  task automatic test_latency_enable();
    int e0;
    logic [31:0] r;
    logic [31:0] nl;
    r  = 32'h13579B;
    nl = 32'h5A5A5A;
    push_exp(24'h2468AC, 24'h13579B);
    send_word(1'b0, 32'h2468AC, WIDTH);
    for (int i = WIDTH - 1; i >= 1; i--) send_bit(1'b1, r[i]);
    // Hand-driven right LSB so the sclk rise lands at a known clk edge.
    @(negedge clk);
    sclk  = 1'b0;
    lrclk = 1'b0;
    sd    = r[0];
    repeat (HALF - 1) @(negedge clk);
    sclk = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (k == 4) begin
        total_cnt++;
        if (valid !== 1'b0) $display("[TB] FAIL latency_early got valid=%b required 0", valid);
        else pass_cnt++;
      end
      if (k == 5) begin
        total_cnt++;
        if (valid !== 1'b1) $display("[TB] FAIL latency_on_time got valid=%b required 1", valid);
        else pass_cnt++;
      end
    end
    repeat (HALF - 5) @(negedge clk);

    e0 = err_pulses;
    for (int i = WIDTH - 1; i >= 12; i--) send_bit(1'b0, nl[i]);
    @(negedge clk);
    enable = 1'b0;
    for (int i = 11; i >= 1; i--) send_bit(1'b0, nl[i]);
    send_bit(1'b1, nl[0]);
    send_word(1'b1, 32'h0F0F0F, WIDTH);
    total_cnt++;
    if (synced !== 1'b0) $display("[TB] FAIL disable_synced got %b required 0", synced);
    else pass_cnt++;
    total_cnt++;
    if (left_data !== last_left || right_data !== last_right)
      $display("[TB] FAIL disable_hold got %h/%h required %h/%h", left_data, right_data, last_left, last_right);
    else pass_cnt++;
    total_cnt++;
    if (err_pulses != e0) $display("[TB] FAIL disable_err got %0d required %0d", err_pulses, e0);
    else pass_cnt++;
    enable = 1'b1;
    send_word(1'b1, 32'h0, WIDTH);
    total_cnt++;
    if (synced !== 1'b1) $display("[TB] FAIL reenable_synced got %b required 1", synced);
    else pass_cnt++;
    push_exp(24'h7E7E7E, 24'hC0FFEE);
    send_frame(32'h7E7E7E, 32'hC0FFEE);
    total_cnt++;
    if (exp_left_q.size() != 0) $display("[TB] FAIL reenable_pending got %0d required 0", exp_left_q.size());
    else pass_cnt++;
  endtask

  initial begin
    rst    = 1'b1;
    enable = 1'b1;
    sclk   = 1'b0;
    lrclk  = 1'b0;
    sd     = 1'b0;
    $display("[TB] starting i2s_receiver bench");
    test_reset();
    test_basic();
    test_mid_right();
    test_short_left();
    test_long_right();
    test_reset_mid();
    test_latency_enable();
    repeat (10) @(negedge clk);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/i2s_receiver.md
I2S_RECEIVER -- requirements
Module: i2s_receiver

Interface
REQ-001 The block SHALL have parameter WIDTH, default 24, giving the sample word width in bits per channel.
REQ-002 The block SHALL have port clk, input, 1 bit: the system clock, with all logic on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: synchronous active-high reset.
REQ-004 The block SHALL have port enable, input, 1 bit: receive enable.
REQ-005 The block SHALL have port sclk, input, 1 bit: serial bit clock, asynchronous to clk.
REQ-006 The block SHALL have port lrclk, input, 1 bit: word select (0 = left, 1 = right), asynchronous to clk.
REQ-007 The block SHALL have port sd, input, 1 bit: serial data, MSB first, asynchronous to clk.
REQ-008 The block SHALL have port left_data, output, WIDTH bits, signed: last complete left sample.
REQ-009 The block SHALL have port right_data, output, WIDTH bits, signed: last complete right sample.
REQ-010 The block SHALL have port valid, output, 1 bit: one-clk pulse when left_data and right_data update.
REQ-011 The block SHALL have port frame_err, output, 1 bit: one-clk pulse on a malformed word.
REQ-012 The block SHALL have port synced, output, 1 bit: high while frame-aligned.

Function
REQ-013 The block SHALL pass sclk, lrclk and sd each through a 2-flop synchronizer, then detect sclk rising edges with one further flop; the clk frequency is at least 4x the sclk frequency.
REQ-014 The block SHALL perform a bit event on each detected sclk rising edge: sample the synchronized sd and lrclk, and keep ws_d = the lrclk value from the previous bit event.
REQ-015 The block SHALL use I2S framing (one-bit delay): lrclk toggles one bit before the MSB, so a bit event with lrclk != ws_d carries the LSB of the current word, and the next bit is the MSB of the other channel.
REQ-016 The block SHALL implement an FSM with states SYNC, LEFT and RIGHT; synced = 1 in LEFT and RIGHT.
REQ-017 SYNC SHALL go to LEFT on a bit event with ws_d = 1 and lrclk = 0, discarding that bit, and SHALL ignore all other events.
REQ-018 LEFT and RIGHT SHALL shift sd into a WIDTH-bit shift register MSB-first and increment a bit counter per event; the counter includes the boundary bit and saturates at WIDTH+1, with no wrap.
REQ-019 In LEFT, at a boundary event (lrclk = 1): if count = WIDTH, the block SHALL latch the shift register into the left holding register, clear the counter and go to RIGHT; otherwise it SHALL pulse frame_err and go to SYNC.
REQ-020 In RIGHT, at a boundary event (lrclk = 0): if count = WIDTH, the block SHALL copy the left holding register to left_data and the shift register to right_data in the same clk, pulse valid for 1 clk, clear the counter and go to LEFT; otherwise it SHALL pulse frame_err and go to SYNC, leaving the outputs unchanged.
REQ-021 A boundary with count < WIDTH (short word), or count > WIDTH (long word), SHALL be a frame error.
REQ-022 left_data and right_data SHALL change only with valid and SHALL hold between pulses.
REQ-023 Latency: valid SHALL rise exactly 4 clk cycles after the first clk edge that samples the right-LSB sclk rise high at the pin.
REQ-024 valid and frame_err SHALL never be high in the same cycle, and neither SHALL be high for more than 1 consecutive clk.
REQ-025 enable = 0 SHALL force SYNC, clear the counter and suppress valid/frame_err, while left_data and right_data hold.
REQ-026 On enable rising, the block SHALL re-acquire via SYNC; the first valid follows one full left+right pair.

Reset
REQ-027 With rst = 1 at a clk edge, the block SHALL clear the synchronizers, shift register, holding register, counter, left_data, right_data, valid, frame_err and synced to 0, and set state SYNC.
REQ-028 rst SHALL take priority over enable and bit events.
REQ-029 A reset mid-word SHALL discard partial data, and no valid SHALL occur until a complete pair has been received after reset.

Verification
REQ-030 Reset, enable = 1, WIDTH = 24, three I2S frames (left = 0x123456, right = 0xFEDCBA, sclk = clk/40) -> after the first aligned pair, exactly one valid per frame with left_data = 0x123456 and right_data = 0xFEDCBA (negative), frame_err never set.
REQ-031 Stream starting mid-right-word -> synced = 0 until the first 1->0 lrclk boundary, the partial pair is dropped, and the first valid carries the next complete pair.
REQ-032 Left word of 23 bits, then correct frames -> one frame_err pulse, synced drops, outputs unchanged, then resync and correct valid on the next full pair.
REQ-033 Right word of 25 bits -> frame_err at the right boundary, no valid that frame, and the previous left_data/right_data are retained.
REQ-034 rst pulsed 1 clk at the 10th bit of a left word -> all outputs 0 the following cycle, no valid until a full subsequent pair, and no spurious frame_err.
REQ-035 Latency check, and enable deasserted mid-frame -> valid exactly 4 clk cycles after the right-LSB sclk rise; with enable low, no pulses occur and the outputs hold.
